// File: rtl/sdinit_pkg.sv
// Shared types and constants for the SD card initialisation sequencer.
package sdinit_pkg;

  // Sequencer states; every command state has an issue and a wait sub-phase.
  typedef enum logic [3:0] {
    StIdle,
    StCmd0,
    StCmd8,
    StCmd55,
    StAcmd41,
    StCmd2,
    StCmd3,
    StCmd7,
    StDone,
    StErr
  } state_e;

  // Abort causes reported on err_code.
  localparam logic [3:0] ErrCmd8       = 4'd2;
  localparam logic [3:0] ErrCmd55      = 4'd3;
  localparam logic [3:0] ErrAcmd41To   = 4'd4;
  localparam logic [3:0] ErrAcmd41Busy = 4'd5;
  localparam logic [3:0] ErrCmd2       = 4'd6;
  localparam logic [3:0] ErrCmd3       = 4'd7;
  localparam logic [3:0] ErrCmd7       = 4'd8;

  // Command indices.
  localparam logic [5:0] CmdGoIdle     = 6'd0;
  localparam logic [5:0] CmdSendIfCond = 6'd8;
  localparam logic [5:0] CmdAppCmd     = 6'd55;
  localparam logic [5:0] CmdSdSendOp   = 6'd41;
  localparam logic [5:0] CmdAllSendCid = 6'd2;
  localparam logic [5:0] CmdSendRca    = 6'd3;
  localparam logic [5:0] CmdSelect     = 6'd7;

  // Command arguments.
  localparam logic [31:0] Cmd8Arg      = 32'h0000_01AA;
  localparam logic [31:0] Acmd41ArgHcs = 32'h40FF_8000;
  localparam logic [31:0] Acmd41ArgStd = 32'h00FF_8000;

  // Idle SD clocks ahead of a command; CMD0 needs the long power-up run.
  localparam logic [15:0] PrecntCmd0  = 16'd80;
  localparam logic [15:0] PrecntOther = 16'd2;

  function automatic logic is_cmd_state(state_e s);
    return s inside {StCmd0, StCmd8, StCmd55, StAcmd41, StCmd2, StCmd3, StCmd7};
  endfunction

endpackage

// File: rtl/sdcard_init_seq.sv
// SD card identification sequencer: drives CMD0/8/55/ACMD41/2/3/7 through an
// external command engine and reports card type, CCS and RCA.
module sdcard_init_seq
  import sdinit_pkg::*;
#(
  parameter logic [15:0] SLOWDIV      = 16'd250,
  parameter logic [15:0] FASTDIV      = 16'd2,
  parameter int unsigned ACMD41_TRIES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  output logic        sdclken,
  output logic [15:0] cmd_clkdiv,
  output logic        cmd_start,
  output logic [15:0] cmd_precnt,
  output logic [5:0]  cmd_cmd,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxe,
  input  logic [31:0] cmd_resparg,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_code,
  output logic        sdv2,
  output logic        card_hcs,
  output logic [15:0] rca
);

  localparam logic [15:0] TriesInit = ACMD41_TRIES[15:0];

  state_e      state_q, state_d;
  logic        wait_q, wait_d;  // 0: issue phase, 1: waiting for cmd_done
  logic [15:0] retry_q, retry_d;
  logic [15:0] rca_q, rca_d;
  logic [15:0] clkdiv_q, clkdiv_d;
  logic        sdv2_q, sdv2_d;
  logic        hcs_q, hcs_d;
  logic [3:0]  err_q, err_d;
  logic        in_cmd, issue_ok, fail;
  logic        unused_resp;

  assign in_cmd      = is_cmd_state(state_q);
  assign issue_ok    = in_cmd & ~wait_q & ~cmd_busy & ~cmd_done;
  assign fail        = cmd_timeout | cmd_syntaxe;
  assign unused_resp = ^cmd_resparg[15:12];

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wait_q   <= 1'b0;
      retry_q  <= '0;
      rca_q    <= '0;
      clkdiv_q <= SLOWDIV;
      sdv2_q   <= 1'b0;
      hcs_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retry_q  <= retry_d;
      rca_q    <= rca_d;
      clkdiv_q <= clkdiv_d;
      sdv2_q   <= sdv2_d;
      hcs_q    <= hcs_d;
      err_q    <= err_d;
    end
  end

  // Next-state and status updates; responses are judged only in the done cycle.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retry_d  = retry_q;
    rca_d    = rca_q;
    clkdiv_d = clkdiv_q;
    sdv2_d   = sdv2_q;
    hcs_d    = hcs_q;
    err_d    = err_q;
    if (!in_cmd) begin
      if (init_start) begin
        state_d  = StCmd0;
        wait_d   = 1'b0;
        err_d    = '0;
        sdv2_d   = 1'b0;
        hcs_d    = 1'b0;
        rca_d    = '0;
        clkdiv_d = SLOWDIV;
        retry_d  = TriesInit;
      end
    end else if (!wait_q) begin
      if (issue_ok) wait_d = 1'b1;
    end else if (cmd_done) begin
      wait_d = 1'b0;
      case (state_q)
        StCmd0: state_d = StCmd8;
        StCmd8: begin
          if (cmd_timeout) begin
            sdv2_d  = 1'b0;
            state_d = StCmd55;
          end else if (!cmd_syntaxe && cmd_resparg[11:0] == Cmd8Arg[11:0]) begin
            sdv2_d  = 1'b1;
            state_d = StCmd55;
          end else begin
            state_d = StErr;
            err_d   = ErrCmd8;
          end
        end
        StCmd55: begin
          if (fail) begin
            state_d = StErr;
            err_d   = ErrCmd55;
          end else begin
            state_d = StAcmd41;
          end
        end
        StAcmd41: begin
          // R3 carries no CRC, so syntaxe is not a failure here.
          if (cmd_timeout) begin
            state_d = StErr;
            err_d   = ErrAcmd41To;
          end else if (cmd_resparg[31]) begin
            hcs_d   = cmd_resparg[30];
            state_d = StCmd2;
          end else begin
            retry_d = (retry_q != 16'd0) ? retry_q - 16'd1 : 16'd0;
            if (retry_q <= 16'd1) begin
              state_d = StErr;
              err_d   = ErrAcmd41Busy;
            end else begin
              state_d = StCmd55;
            end
          end
        end
        StCmd2: begin
          if (fail) begin
            state_d = StErr;
            err_d   = ErrCmd2;
          end else begin
            state_d = StCmd3;
          end
        end
        StCmd3: begin
          if (fail) begin
            state_d = StErr;
            err_d   = ErrCmd3;
          end else begin
            rca_d   = cmd_resparg[31:16];
            state_d = StCmd7;
          end
        end
        StCmd7: begin
          if (fail) begin
            state_d = StErr;
            err_d   = ErrCmd7;
          end else begin
            clkdiv_d = FASTDIV;
            state_d  = StDone;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Command fields decoded from the state so they hold through the wait phase.
  always_comb begin
    cmd_start  = issue_ok;
    cmd_cmd    = '0;
    cmd_arg    = '0;
    cmd_precnt = in_cmd ? PrecntOther : 16'd0;
    case (state_q)
      StCmd0: begin
        cmd_cmd    = CmdGoIdle;
        cmd_precnt = PrecntCmd0;
      end
      StCmd8: begin
        cmd_cmd = CmdSendIfCond;
        cmd_arg = Cmd8Arg;
      end
      StCmd55: cmd_cmd = CmdAppCmd;
      StAcmd41: begin
        cmd_cmd = CmdSdSendOp;
        cmd_arg = sdv2_q ? Acmd41ArgHcs : Acmd41ArgStd;
      end
      StCmd2: cmd_cmd = CmdAllSendCid;
      StCmd3: cmd_cmd = CmdSendRca;
      StCmd7: begin
        cmd_cmd = CmdSelect;
        cmd_arg = {rca_q, 16'h0000};
      end
      default: cmd_cmd = '0;
    endcase
    init_busy  = in_cmd;
    sdclken    = in_cmd | (state_q == StDone);
    init_done  = (state_q == StDone);
    init_err   = (state_q == StErr);
    cmd_clkdiv = clkdiv_q;
    err_code   = err_q;
    sdv2       = sdv2_q;
    card_hcs   = hcs_q;
    rca        = rca_q;
  end

endmodule

// File: tb/tb_sdcard_init_seq.sv
// Bench for sdcard_init_seq: command-engine model, transaction-level reference
// model and a per-cycle compare process.
module tb_sdcard_init_seq;

  localparam logic [15:0] Slow  = 16'd250;
  localparam logic [15:0] Fast  = 16'd2;
  localparam int          Tries = 3;

  logic        clk = 1'b0, rst = 1'b1, init_start = 1'b0;
  logic        sdclken, cmd_start, init_busy, init_done, init_err, sdv2, card_hcs;
  logic [15:0] cmd_clkdiv, cmd_precnt, rca;
  logic [5:0]  cmd_cmd;
  logic [31:0] cmd_arg;
  logic [3:0]  err_code;
  logic        cmd_busy = 1'b0, cmd_done = 1'b0, cmd_timeout = 1'b0, cmd_syntaxe = 1'b0;
  logic [31:0] cmd_resparg = '0;

  int n_cmp = 0, n_bad = 0;
  bit tb_ready = 0;

  always #5 clk = ~clk;

  sdcard_init_seq #(
    .SLOWDIV     (Slow),
    .FASTDIV     (Fast),
    .ACMD41_TRIES(Tries)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .sdclken    (sdclken),
    .cmd_clkdiv (cmd_clkdiv),
    .cmd_start  (cmd_start),
    .cmd_precnt (cmd_precnt),
    .cmd_cmd    (cmd_cmd),
    .cmd_arg    (cmd_arg),
    .cmd_busy   (cmd_busy),
    .cmd_done   (cmd_done),
    .cmd_timeout(cmd_timeout),
    .cmd_syntaxe(cmd_syntaxe),
    .cmd_resparg(cmd_resparg),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_code   (err_code),
    .sdv2       (sdv2),
    .card_hcs   (card_hcs),
    .rca        (rca)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Card scenario: cmd8 mode 0 echo 1AA, 1 timeout, 2 echo 0AA.
  int          sc_cmd8, sc_busy_rounds;
  logic [31:0] sc_ocr;
  logic [15:0] sc_rca;
  bit          sc_cmd3_syn;

  // Expected command list and final outcome for the scenario.
  typedef struct packed {logic [5:0] cmd; logic [31:0] arg; logic [15:0] pre;} cmd_t;
  cmd_t        exp_q[$];
  bit          f_done, f_sdv2, f_hcs;
  logic [3:0]  f_code;
  logic [15:0] f_rca;

  function automatic void push(logic [5:0] c, logic [31:0] a, logic [15:0] p);
    exp_q.push_back({c, a, p});
  endfunction

  function automatic void build_model();
    bit ready = 0;
    exp_q.delete();
    f_done = 0; f_sdv2 = 0; f_hcs = 0; f_code = 0; f_rca = 0;
    push(6'd0, 32'h0, 16'd80);
    push(6'd8, 32'h1AA, 16'd2);
    if (sc_cmd8 == 2) begin
      f_code = 4'd2;
      return;
    end
    f_sdv2 = (sc_cmd8 == 0);
    for (int r = 1; r <= Tries; r++) begin
      push(6'd55, 32'h0, 16'd2);
      push(6'd41, f_sdv2 ? 32'h40FF8000 : 32'h00FF8000, 16'd2);
      if (r > sc_busy_rounds) begin
        ready = 1;
        break;
      end
    end
    if (!ready) begin
      f_code = 4'd5;
      return;
    end
    f_hcs = sc_ocr[30];
    push(6'd2, 32'h0, 16'd2);
    push(6'd3, 32'h0, 16'd2);
    if (sc_cmd3_syn) begin
      f_code = 4'd7;
      return;
    end
    f_rca = sc_rca;
    push(6'd7, {sc_rca, 16'h0}, 16'd2);
    f_done = 1;
  endfunction

  // Command engine: busy from after the start, one-cycle done, busy drops after done.
  logic [5:0] eng_cmd = '0;
  int         acmd_cnt = 0;

  task automatic respond(input logic [5:0] c);
    logic [31:0] r;
    r = $urandom();
    cmd_timeout = 1'b0;
    cmd_syntaxe = 1'b0;
    cmd_resparg = r;
    case (c)
      6'd0: begin
        cmd_timeout = 1'($urandom_range(0, 1));
        cmd_syntaxe = 1'($urandom_range(0, 1));
      end
      6'd8: begin
        if (sc_cmd8 == 1) cmd_timeout = 1'b1;
        else cmd_resparg = {r[31:12], (sc_cmd8 == 0) ? 12'h1AA : 12'h0AA};
      end
      6'd41: begin
        acmd_cnt++;
        cmd_syntaxe = 1'($urandom_range(0, 1));
        if (acmd_cnt <= sc_busy_rounds) cmd_resparg = {1'b0, r[30:0]};
        else cmd_resparg = {1'b1, sc_ocr[30:0]};
      end
      6'd3: begin
        cmd_syntaxe = sc_cmd3_syn;
        cmd_resparg = {sc_rca, r[15:0]};
      end
      default: ;
    endcase
  endtask

  initial begin
    int  lat;
    logic st;
    logic [5:0] c;
    lat = 0;
    forever begin
      @(negedge clk);
      st = cmd_start;
      c  = cmd_cmd;
      @(posedge clk);
      #1;
      if (cmd_done) begin
        cmd_done = 1'b0;
        cmd_busy = 1'b0;
        cmd_timeout = 1'b0;
        cmd_syntaxe = 1'b0;
      end else if (st === 1'b1) begin
        cmd_busy = 1'b1;
        eng_cmd  = c;
        lat      = $urandom_range(0, 3);
      end else if (cmd_busy) begin
        if (lat == 0) begin
          respond(eng_cmd);
          cmd_done = 1'b1;
        end else lat--;
      end
    end
  end

  // Reference model state, advanced once per cycle from observed events.
  bit          m_run = 0, m_done = 0, m_err = 0, m_out = 0, m_sdv2 = 0, m_hcs = 0;
  logic [3:0]  m_code = 0;
  logic [15:0] m_rca = 0;
  int          iss_idx = 0, done_idx = 0;
  cmd_t        cap;
  int          cnt55 = 0, cnt41 = 0;
  logic [31:0] arg41 = 0, arg7 = 0;
  logic [15:0] pre_first = 0;
  bit          first_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (tb_ready) begin
        chk("init_busy", init_busy, m_run);
        chk("sdclken", sdclken, m_run | m_done);
        chk("init_done", init_done, m_done);
        chk("init_err", init_err, m_err);
        chk("cmd_clkdiv", cmd_clkdiv, m_done ? Fast : Slow);
        if (!m_run) begin
          chk("start_idle", cmd_start, 0);
          chk("err_code", err_code, m_code);
          chk("sdv2", sdv2, m_sdv2);
          chk("card_hcs", card_hcs, m_hcs);
          chk("rca", rca, m_rca);
        end
        if (m_out) begin
          chk("hold_cmd", cmd_cmd, cap.cmd);
          chk("hold_arg", cmd_arg, cap.arg);
          chk("hold_pre", cmd_precnt, cap.pre);
        end
        if (m_run && cmd_start) begin
          chk("start_legal", {m_out, cmd_busy, cmd_done}, 0);
          if (iss_idx < exp_q.size()) begin
            chk("start_cmd", cmd_cmd, exp_q[iss_idx].cmd);
            chk("start_arg", cmd_arg, exp_q[iss_idx].arg);
            chk("start_pre", cmd_precnt, exp_q[iss_idx].pre);
          end else chk("extra_start", cmd_start, 0);
        end
        // Advance the model.
        if (rst) begin
          m_run = 0; m_done = 0; m_err = 0; m_out = 0;
          m_sdv2 = 0; m_hcs = 0; m_code = 0; m_rca = 0;
        end else if (!m_run) begin
          if (init_start) begin
            m_run = 1; m_done = 0; m_err = 0; m_out = 0;
            m_sdv2 = 0; m_hcs = 0; m_code = 0; m_rca = 0;
            iss_idx = 0; done_idx = 0;
          end
        end else if (cmd_start) begin
          m_out = 1;
          cap   = {cmd_cmd, cmd_arg, cmd_precnt};
          iss_idx++;
          if (!first_seen) begin
            pre_first  = cmd_precnt;
            first_seen = 1;
          end
          if (cmd_cmd == 6'd55) cnt55++;
          if (cmd_cmd == 6'd41) begin
            cnt41++;
            arg41 = cmd_arg;
          end
          if (cmd_cmd == 6'd7) arg7 = cmd_arg;
        end else if (m_out && cmd_done) begin
          m_out = 0;
          done_idx++;
          if (done_idx == exp_q.size()) begin
            m_run = 0; m_done = f_done; m_err = !f_done; m_code = f_code;
            m_sdv2 = f_sdv2; m_hcs = f_hcs; m_rca = f_rca;
          end
        end
      end
    end
  end

  task automatic run(input int c8, input int br, input logic [31:0] ocr, input logic [15:0] rc,
                     input bit s3, input bit poke, input bit rst_mid);
    bit ended, poked;
    sc_cmd8 = c8; sc_busy_rounds = br; sc_ocr = ocr; sc_rca = rc; sc_cmd3_syn = s3;
    build_model();
    acmd_cnt = 0; cnt55 = 0; cnt41 = 0; arg41 = 0; arg7 = 0; first_seen = 0; pre_first = 0;
    ended = 0; poked = 0;
    @(posedge clk);
    #1 init_start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      init_start = 1'b0;
      if (!m_run) begin
        ended = 1;
        break;
      end
      if (poke && !poked && cmd_busy && eng_cmd == 6'd2) begin
        init_start = 1'b1;
        poked = 1;
      end
      if (rst_mid && cmd_busy && !cmd_done && eng_cmd == 6'd41) begin
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        ended = 1;
        break;
      end
    end
    if (!ended) chk("run_timeout", 1, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1 tb_ready = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_clkdiv", cmd_clkdiv, 16'd250);
    chk("rst_start", cmd_start, 0);
    chk("rst_sdclken", sdclken, 0);

    // SDHC card: two busy rounds then ready with CCS.
    run(0, 2, 32'hC0FF8000, 16'h1234, 0, 0, 0);
    chk("sdhc_done", init_done, 1);
    chk("sdhc_sdv2", sdv2, 1);
    chk("sdhc_hcs", card_hcs, 1);
    chk("sdhc_rca", rca, 16'h1234);
    chk("sdhc_clkdiv", cmd_clkdiv, 16'd2);
    chk("sdhc_arg7", arg7, 32'h12340000);
    chk("sdhc_n41", cnt41, 3);

    // v1 card: CMD8 times out.
    run(1, 0, 32'h80FF8000, 16'h0042, 0, 0, 0);
    chk("v1_sdv2", sdv2, 0);
    chk("v1_hcs", card_hcs, 0);
    chk("v1_arg41", arg41, 32'h00FF8000);
    chk("v1_done", init_done, 1);

    // Card never ready.
    run(0, 100, 32'hC0FF8000, 16'h1111, 0, 0, 0);
    chk("busy_n55", cnt55, 3);
    chk("busy_n41", cnt41, 3);
    chk("busy_err", init_err, 1);
    chk("busy_code", err_code, 5);
    chk("busy_sdclken", sdclken, 0);

    // Bad CMD8 echo, CMD3 syntax error.
    run(2, 0, 32'hC0FF8000, 16'h1111, 0, 0, 0);
    chk("cmd8_code", err_code, 2);
    run(0, 0, 32'hC0FF8000, 16'h2222, 1, 0, 0);
    chk("cmd3_code", err_code, 7);

    // Reset during ACMD41 wait, then a clean restart.
    run(0, 2, 32'hC0FF8000, 16'h1234, 0, 0, 1);
    chk("rstmid_busy", init_busy, 0);
    chk("rstmid_sdclken", sdclken, 0);
    chk("rstmid_clkdiv", cmd_clkdiv, 16'd250);
    chk("rstmid_start", cmd_start, 0);
    chk("rstmid_fields", {cmd_cmd, cmd_precnt}, 0);
    chk("rstmid_arg", cmd_arg, 0);
    chk("rstmid_stat", {init_done, init_err, err_code, sdv2, card_hcs}, 0);
    chk("rstmid_rca", rca, 0);
    repeat (8) @(posedge clk);
    run(0, 0, 32'h80FF8000, 16'hBEEF, 0, 0, 0);
    chk("restart_pre", pre_first, 16'd80);
    chk("restart_done", init_done, 1);

    // init_start during CMD2 must be ignored.
    run(0, 1, 32'hC0FF8000, 16'h5A5A, 0, 1, 0);
    chk("poke_done", init_done, 1);
    chk("poke_rca", rca, 16'h5A5A);

    // Randomised cards.
    for (int k = 0; k < 24; k++) begin
      r = $urandom();
      run($urandom_range(0, 2), $urandom_range(0, 4), {1'b1, r[30:0]}, 16'($urandom()),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdcard_init_seq.md
SDCARD_INIT_SEQ -- requirements
Module: sdcard_init_seq

Interface
REQ-001 SHALL have parameter SLOWDIV, default 16'd250, clkdiv used during identification (about 400 kHz).
REQ-002 SHALL have parameter FASTDIV, default 16'd2, clkdiv applied after successful init.
REQ-003 SHALL have parameter ACMD41_TRIES, default 1000, maximum CMD55/ACMD41 rounds.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- init_start  in  1  pulse requesting card init.
- sdclken  out  1  SD clock enable to command engine.
- cmd_clkdiv  out  16  clock divider to command engine.
- cmd_start  out  1  one-cycle command launch.
- cmd_precnt  out  16  idle SD clocks before command.
- cmd_cmd  out  6  command index.
- cmd_arg  out  32  command argument.
- cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe  in  1 each  command engine status.
- cmd_resparg  in  32  response argument.
- init_busy  out  1  sequence running.
- init_done  out  1  level, card in transfer state.
- init_err  out  1  level, sequence aborted.
- err_code  out  4  abort cause.
- sdv2  out  1  card answered CMD8.
- card_hcs  out  1  CCS bit from OCR.
- rca  out  16  relative card address.

Function
REQ-005 SHALL implement states IDLE, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, CMD7, DONE, ERR; each CMD state has ISSUE and WAIT sub-phases.
REQ-006 In ISSUE, SHALL pulse cmd_start for exactly one cycle only when cmd_busy=0 and cmd_done=0, then enter WAIT; cmd_cmd, cmd_arg and cmd_precnt SHALL be stable from the start cycle until cmd_done.
REQ-007 In WAIT, SHALL evaluate only the cycle cmd_done=1, using cmd_timeout, cmd_syntaxe and cmd_resparg sampled in that cycle.
REQ-008 cmd_precnt SHALL be 16'd80 for CMD0 and 16'd2 for all others.
REQ-009 IDLE/DONE/ERR + init_start=1 -> CMD0; SHALL clear init_done, init_err, err_code, sdv2, card_hcs and rca, and set cmd_clkdiv=SLOWDIV and the retry counter to ACMD41_TRIES.
REQ-010 init_start SHALL be ignored in all other states.
REQ-011 CMD0 (arg 0): any completion, including timeout or syntax error, -> CMD8.
REQ-012 CMD8 (arg 32'h000001AA):
- timeout -> sdv2=0, go CMD55.
- clean response with resparg[11:0]=12'h1AA -> sdv2=1, go CMD55.
- otherwise -> ERR, code 2.
REQ-013 CMD55 (arg 0): timeout or syntaxe -> ERR code 3; else -> ACMD41.
REQ-014 ACMD41 (arg 32'h40FF8000 if sdv2, else 32'h00FF8000): syntaxe SHALL be ignored (R3 carries no CRC).
- timeout -> ERR code 4.
- resparg[31]=1 -> card_hcs=resparg[30], go CMD2.
- else decrement retry counter; reaching 0 -> ERR code 5, otherwise -> CMD55.
REQ-015 CMD2 (arg 0): timeout or syntaxe -> ERR code 6; else -> CMD3.
REQ-016 CMD3 (arg 0): timeout or syntaxe -> ERR code 7; else rca=resparg[31:16], go CMD7.
REQ-017 CMD7 (arg {rca,16'h0}): timeout or syntaxe -> ERR code 8; else cmd_clkdiv=FASTDIV, go DONE.
REQ-018 DONE SHALL hold init_done=1; ERR SHALL hold init_err=1 with err_code held.
REQ-019 init_busy SHALL be 1 exactly in CMD0..CMD7.
REQ-020 sdclken SHALL be 1 in CMD0..CMD7 and DONE, and 0 in IDLE and ERR.
REQ-021 The retry counter SHALL be 16 bits wide and SHALL NOT wrap.

Reset
REQ-022 rst SHALL force IDLE and set every output to 0, except cmd_clkdiv=SLOWDIV, and the retry counter to 0, including mid-command.
REQ-023 SHALL issue no cmd_start in the cycle after rst deasserts.

Structure
REQ-024 Package sdinit_pkg SHALL hold the state enum, the err_code constants (2..8), the command index constants and the CMD8/ACMD41 argument constants.
REQ-025 SHALL be a single module with no sub-module; it connects to the existing SD command engine.

Verification
REQ-026 The bench SHALL model the command engine (busy/done timing, one-cycle done, busy clears the cycle after done) and cover:
- SDHC card: CMD8 echo 0x1AA, ACMD41 busy 2x then 0xC0FF8000, CMD3 rca=0x1234 -> init_done, sdv2=1, card_hcs=1, rca=0x1234, cmd_clkdiv=2, CMD7 arg=0x12340000.
- v1 card: CMD8 timeout, ACMD41 0x80FF8000 -> sdv2=0, card_hcs=0, ACMD41 arg=0x00FF8000.
- ACMD41_TRIES=3, card never ready -> exactly 3 CMD55/ACMD41 pairs, init_err=1, err_code=5, sdclken=0.
- CMD8 echo 0x0AA -> err_code=2; CMD3 syntaxe -> err_code=7.
- rst asserted mid-ACMD41 WAIT -> next cycle IDLE, all outputs at reset values; a new init_start restarts at CMD0 with precnt 80.
- init_start pulsed during CMD2 -> ignored; a single cmd_start per command throughout.
